// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the pointer-advance helper.
package rr_arbiter8_pkg;

  localparam int ARB_N        = 8;    // requesters; fixed to match the 8-to-3 encoder
  localparam int ARB_PTR_W    = 3;    // clog2(ARB_N)
  localparam int ARB_HOLD_MAX = 255;  // default hold limit; 0 disables the timeout
  localparam int ARB_CNT_W    = 8;    // hold counter width, must hold ARB_HOLD_MAX

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Priority moves to the requester just after the released owner; 7 wraps to 0
  // because the pointer is exactly ARB_PTR_W bits wide.
  function automatic logic [ARB_PTR_W-1:0] ptr_after(input logic [ARB_PTR_W-1:0] owner);
    return owner + ARB_PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter8_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request bit
// at or after ptr (wrapping), as a one-hot vector and as an index.
module rr_pick
  import rr_arbiter8_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_PTR_W-1:0] ptr,
  output logic [ARB_N-1:0]     pick,
  output logic [ARB_PTR_W-1:0] idx
);

  logic [2*ARB_N-1:0]   dbl_req_s;   // req concatenated with itself
  logic [ARB_N-1:0]     win_s;       // req rotated so that ptr sits at bit 0
  logic [ARB_N-1:0]     sel_s;       // lowest set bit of win_s
  logic [2*ARB_N-1:0]   dbl_sel_s;   // sel_s doubled for the rotate-back
  logic [ARB_PTR_W-1:0] idx_rel_s;   // winner position relative to ptr

  assign dbl_req_s = {req, req};
  assign win_s     = ARB_N'(dbl_req_s >> ptr);
  assign sel_s     = win_s & (~win_s + ARB_N'(1));
  assign dbl_sel_s = {sel_s, sel_s};
  assign pick      = ARB_N'((dbl_sel_s << ptr) >> ARB_N);
  assign idx       = ptr + idx_rel_s;

  // Encode the one-hot rotated winner into its relative index.
  always_comb begin
    idx_rel_s = {ARB_PTR_W{1'b0}};
    for (int i = 0; i < ARB_N; i++) begin
      if (sel_s[i]) begin
        idx_rel_s = ARB_PTR_W'(i);
      end else begin
        idx_rel_s = idx_rel_s;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Registered round-robin arbiter for 8 requesters. A one-hot grant is held
// until done or until the hold timer expires, with an idle cycle between grants.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = ARB_HOLD_MAX,
  parameter int CNT_W    = ARB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ARB_N-1:0] req,
  input  logic             done,
  output logic [ARB_N-1:0] grant,
  output logic             grant_valid,
  output logic             timeout
);

  localparam logic             HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  arb_state_e           state_r, state_n_s;
  logic [ARB_PTR_W-1:0] ptr_r, ptr_n_s;
  logic [ARB_PTR_W-1:0] owner_r, owner_n_s;
  logic [CNT_W-1:0]     cnt_r, cnt_n_s;
  logic [ARB_N-1:0]     grant_n_s;
  logic                 timeout_n_s;
  logic [ARB_N-1:0]     pick_s;
  logic [ARB_PTR_W-1:0] pick_idx_s;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_r),
    .pick (pick_s),
    .idx  (pick_idx_s)
  );

  // Next-state logic: arbitrate in IDLE, hold and watch done/timer in GRANT.
  always_comb begin
    state_n_s   = state_r;
    ptr_n_s     = ptr_r;
    owner_n_s   = owner_r;
    cnt_n_s     = cnt_r;
    grant_n_s   = grant;
    timeout_n_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_n_s = ST_GRANT;
          grant_n_s = pick_s;
          owner_n_s = pick_idx_s;
          cnt_n_s   = {CNT_W{1'b0}};
        end else begin
          grant_n_s = {ARB_N{1'b0}};
        end
      end
      ST_GRANT: begin
        if (done) begin
          state_n_s = ST_IDLE;
          grant_n_s = {ARB_N{1'b0}};
          ptr_n_s   = ptr_after(owner_r);
        end else if (HOLD_EN && (cnt_r == HOLD_LAST)) begin
          state_n_s   = ST_IDLE;
          grant_n_s   = {ARB_N{1'b0}};
          ptr_n_s     = ptr_after(owner_r);
          timeout_n_s = 1'b1;
        end else if (cnt_r != CNT_SAT) begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_n_s = cnt_r;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        grant_n_s = {ARB_N{1'b0}};
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ARB_PTR_W{1'b0}};
      owner_r     <= {ARB_PTR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      grant       <= {ARB_N{1'b0}};
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      ptr_r       <= ptr_n_s;
      owner_r     <= owner_n_s;
      cnt_r       <= cnt_n_s;
      grant       <= grant_n_s;
      grant_valid <= |grant_n_s;
      timeout     <= timeout_n_s;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;   // number of cycles the current grant has been visible
  bit m_to;

  rr_arbiter8 #(.HOLD_MAX(HM), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // What one clock edge does, described from the arbitration rules.
  task automatic model_edge(input bit rst_v, input logic [7:0] req_v, input bit done_v);
    m_to = 1'b0;
    if (rst_v) begin
      m_busy = 1'b0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      if (req_v != 8'h00) begin
        for (int k = 7; k >= 0; k--) begin
          if (req_v[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        end
        m_busy = 1'b1;
        m_held = 1;
      end
    end else if (done_v) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 8;
    end else if (HM != 0 && m_held == HM) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % 8;
      m_to   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  // Apply one cycle of inputs, advance model, compare all outputs after the edge.
  task automatic step(input bit rst_v, input logic [7:0] req_v, input bit done_v);
    logic [7:0] exp_g;
    reset = rst_v; req = req_v; done = done_v;
    @(posedge clk);
    model_edge(rst_v, req_v, done_v);
    #1;
    exp_g = m_busy ? (8'h01 << m_owner) : 8'h00;
    chk("grant", {24'h0, grant}, {24'h0, exp_g});
    chk("grant_valid", {31'h0, grant_valid}, {31'h0, m_busy});
    chk("timeout", {31'h0, timeout}, {31'h0, m_to});
  endtask

  initial begin
    reset = 1'b1; req = 8'h00; done = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;

    // 1: reset, then idle
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    chk("idle_grant", {24'h0, grant}, 32'h0);

    // 2: req=24 from ptr 0
    step(1'b0, 8'h24, 1'b0);
    chk("t2_first", {24'h0, grant}, 32'h04);
    step(1'b0, 8'h24, 1'b0);
    step(1'b0, 8'h24, 1'b0);
    step(1'b0, 8'h24, 1'b1);
    chk("t2_gap", {24'h0, grant}, 32'h00);
    step(1'b0, 8'h24, 1'b0);
    chk("t2_second", {24'h0, grant}, 32'h20);
    step(1'b0, 8'h24, 1'b1);
    step(1'b0, 8'hFF, 1'b0);
    chk("t2_ptr6", {24'h0, grant}, 32'h40);
    step(1'b0, 8'hFF, 1'b1);

    // 3: fairness from ptr 0
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 8'hFF, 1'b0);
      chk("t3_rotate", {24'h0, grant}, 32'h1 << (i % 8));
      step(1'b0, 8'hFF, 1'b1);
      chk("t3_gap", {31'h0, grant_valid}, 32'h0);
    end

    // 4: hold timeout
    step(1'b0, 8'h10, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h10, 1'b0);
    chk("t4_held", {24'h0, grant}, 32'h10);
    step(1'b0, 8'h10, 1'b0);
    chk("t4_release", {24'h0, grant}, 32'h00);
    chk("t4_timeout", {31'h0, timeout}, 32'h1);
    step(1'b0, 8'hFF, 1'b0);
    chk("t4_ptr5", {24'h0, grant}, 32'h20);
    chk("t4_pulse", {31'h0, timeout}, 32'h0);
    step(1'b0, 8'hFF, 1'b1);

    // 5: grant held after req drops, then pointer wraps 7->0
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_hold", {24'h0, grant}, 32'h80);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h81, 1'b0);
    chk("t5_wrap", {24'h0, grant}, 32'h01);
    step(1'b0, 8'h81, 1'b1);

    // 6: reset during grant
    step(1'b0, 8'hFF, 1'b0);
    chk("t6_grant", {24'h0, grant}, 32'h02);
    step(1'b1, 8'hFF, 1'b0);
    chk("t6_reset", {24'h0, grant}, 32'h00);
    step(1'b0, 8'h03, 1'b0);
    chk("t6_ptr0", {24'h0, grant}, 32'h01);
    step(1'b0, 8'h03, 1'b1);
    step(1'b0, 8'h02, 1'b0);
    chk("t6_req02", {24'h0, grant}, 32'h02);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), 8'($urandom), ($urandom_range(2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
